// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue_if
// Brief    : PC / instruction-memory / decode handshake bundle for the fetch queue
// Revision : 1.0
// ============================================================================
interface instr_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    // Environment side: PC, memory and decoder
    modport master (
        output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  pc_ready, imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );

    // Fetch queue side
    modport slave (
        input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output pc_ready, imem_req, imem_addr, inst_valid, inst_data, inst_pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Slot-reserved in-order fetch queue with branch flush and response
//            discard. Optional macro FETCH_BYPASS_EN: zero-latency rdata bypass.
// Revision : 1.0
// ============================================================================
module instr_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    instr_fetch_queue_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    // Headroom for discards accumulated over back-to-back flushes
    localparam int DISC_W = PTR_W + 3;

    localparam logic [PTR_W-1:0]  C_PTR_ONE  = PTR_W'(1);
    localparam logic [DISC_W-1:0] C_DISC_ONE = DISC_W'(1);

    logic [PTR_W-1:0]  r_alloc;
    logic [PTR_W-1:0]  r_fill;
    logic [PTR_W-1:0]  r_head;
    logic [DISC_W-1:0] r_discard;
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_filled;

    logic [IDX_W-1:0]  w_alloc_idx;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [IDX_W-1:0]  w_head_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_resp;
    logic              w_byp;
    logic              w_head_rdy;
    logic              w_pop;
    logic              w_issue_ok;
    logic              w_grant;
    logic [PTR_W-1:0]  w_out_cnt;
    logic [DISC_W-1:0] w_inflight;
    logic [DISC_W-1:0] w_flush_disc;

    assign w_alloc_idx = r_alloc[IDX_W-1:0];
    assign w_fill_idx  = r_fill[IDX_W-1:0];
    assign w_head_idx  = r_head[IDX_W-1:0];

    assign w_empty = (r_alloc == r_head);
    assign w_full  = (r_alloc[PTR_W-1] != r_head[PTR_W-1]) &&
                     (r_alloc[IDX_W-1:0] == r_head[IDX_W-1:0]);

    // A response is kept only when nothing is pending discard and a request is outstanding
    assign w_resp = bus.imem_rvalid && !rst && !bus.flush &&
                    (r_discard == '0) && (r_alloc != r_fill);

`ifdef FETCH_BYPASS_EN
    assign w_byp = w_resp && (r_fill == r_head);
`else
    assign w_byp = 1'b0;
`endif

    assign w_head_rdy     = r_filled[w_head_idx] && !w_empty && !rst;
    assign bus.inst_valid = w_head_rdy || w_byp;
    assign bus.inst_data  = w_byp ? bus.imem_rdata : r_data[w_head_idx];
    assign bus.inst_pc    = r_pc[w_head_idx];

    assign w_pop      = bus.inst_valid && bus.inst_ready;
    assign w_issue_ok = !w_full || w_pop;
    assign bus.imem_req  = bus.pc_valid && w_issue_ok && !bus.flush && !rst;
    assign bus.imem_addr = bus.pc_in;
    assign w_grant       = bus.imem_req && bus.imem_gnt;
    assign bus.pc_ready  = w_grant;

    // Everything still owed by memory at a flush, less a response landing in that cycle
    assign w_out_cnt    = r_alloc - r_fill;
    assign w_inflight   = {{(DISC_W-PTR_W){1'b0}}, w_out_cnt} + r_discard;
    assign w_flush_disc = (bus.imem_rvalid && (w_inflight != '0)) ?
                          (w_inflight - C_DISC_ONE) : w_inflight;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alloc   <= '0;
            r_fill    <= '0;
            r_head    <= '0;
            r_discard <= '0;
            r_filled  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (bus.flush) begin
            r_alloc   <= '0;
            r_fill    <= '0;
            r_head    <= '0;
            r_filled  <= '0;
            r_discard <= w_flush_disc;
        end else begin
            if (w_grant) begin
                r_pc[w_alloc_idx]     <= bus.pc_in;
                r_filled[w_alloc_idx] <= 1'b0;
                r_alloc               <= r_alloc + C_PTR_ONE;
            end
            if (bus.imem_rvalid && (r_discard != '0)) begin
                r_discard <= r_discard - C_DISC_ONE;
            end else if (w_resp) begin
                // A bypassed word consumed this cycle never needs to be stored
                if (!(w_byp && w_pop)) begin
                    r_data[w_fill_idx]   <= bus.imem_rdata;
                    r_filled[w_fill_idx] <= 1'b1;
                end
                r_fill <= r_fill + C_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + C_PTR_ONE;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Scoreboard bench for instr_fetch_queue (reset, stream, backpressure,
//            stall, flush)
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_queue;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.pc_valid    = 1'b0;
        bus.pc_in       = '0;
        bus.flush       = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
    endtask

    // Drive a memory response; kept ones are expected at decode in order
    task automatic resp(input logic [31:0] pc, input logic [31:0] d, input bit keep);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        if (keep) sb.push_back({pc, d});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("pop_pc", bus.inst_pc, e.pc);
                check("pop_data", bus.inst_data, e.data);
            end
        end
    end

    initial begin
        int k;
        idle();
        rst          = 1'b1;
        bus.pc_valid = 1'b1;
        bus.imem_gnt = 1'b1;
        bus.pc_in    = 32'h1234;
        @(negedge clk);
        check("rst_req", bus.imem_req, 0);
        check("rst_pc_ready", bus.pc_ready, 0);
        tick();
        @(negedge clk);
        check("rst_req2", bus.imem_req, 0);
        check("rst_pc_ready2", bus.pc_ready, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst_pc", bus.inst_pc, 0);
        check("rst_inst_data", bus.inst_data, 0);
        tick();
        rst = 1'b0;
        idle();

        // Streaming fetch, one response per cycle
        for (int c = 0; c < 7; c++) begin
            bus.inst_ready  = 1'b1;
            bus.imem_gnt    = 1'b1;
            bus.pc_valid    = (c < 4);
            bus.pc_in       = 32'(4 * c);
            bus.imem_rvalid = 1'b0;
            if (c >= 1 && c <= 4) resp(32'(4 * (c - 1)), 32'hA0 + 32'(c - 1), 1'b1);
            @(negedge clk);
            if (c < 4) begin
                check("stream_pc_ready", bus.pc_ready, 1);
                check("stream_addr", bus.imem_addr, 64'(4 * c));
            end
            k = c - LAT - 1;
            check("stream_valid", bus.inst_valid, (k >= 0 && k <= 3) ? 64'd1 : 64'd0);
            if (k >= 0 && k <= 3) check("stream_pc", bus.inst_pc, 64'(4 * k));
            tick();
        end
        idle();

        // Backpressure: four grants fill the queue, one pop admits one more
        for (int b = 0; b < 7; b++) begin
            bus.imem_gnt    = 1'b1;
            bus.pc_valid    = 1'b1;
            bus.pc_in       = (b < 4) ? 32'h100 + 32'(4 * b) : (b == 6) ? 32'h114 : 32'h110;
            bus.imem_rvalid = 1'b0;
            bus.inst_ready  = (b == 5);
            if (b >= 1 && b <= 4) resp(32'h100 + 32'(4 * (b - 1)), 32'hD0 + 32'(b - 1), 1'b1);
            if (b == 6) resp(32'h110, 32'hD4, 1'b1);
            @(negedge clk);
            check("bp_pc_ready", bus.pc_ready, (b < 4 || b == 5) ? 64'd1 : 64'd0);
            if (b == 4) check("bp_req_full", bus.imem_req, 0);
            tick();
        end
        idle();
        for (int d = 0; d < 5; d++) begin
            bus.inst_ready = 1'b1;
            @(negedge clk);
            check("bp_drain_valid", bus.inst_valid, (d < 4) ? 64'd1 : 64'd0);
            tick();
        end
        idle();

        // Memory stall: request held, nothing accepted
        for (int s = 0; s < 3; s++) begin
            bus.inst_ready = 1'b1;
            bus.pc_valid   = 1'b1;
            bus.pc_in      = 32'h200;
            bus.imem_gnt   = 1'b0;
            @(negedge clk);
            check("stall_req", bus.imem_req, 1);
            check("stall_pc_ready", bus.pc_ready, 0);
            check("stall_addr", bus.imem_addr, 64'h200);
            tick();
        end
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        check("stall_release", bus.pc_ready, 1);
        tick();
        bus.pc_valid = 1'b0;
        resp(32'h200, 32'hE0, 1'b1);
        tick();
        idle();
        bus.inst_ready = 1'b1;
        tick();
        tick();

        // Flush with two requests in flight
        idle();
        bus.inst_ready = 1'b1;
        bus.imem_gnt   = 1'b1;
        bus.pc_valid   = 1'b1;
        bus.pc_in      = 32'h10;
        tick();
        bus.pc_in = 32'h14;
        tick();
        bus.flush = 1'b1;
        bus.pc_in = 32'h18;
        @(negedge clk);
        check("flush_req", bus.imem_req, 0);
        check("flush_pc_ready", bus.pc_ready, 0);
        tick();
        bus.flush = 1'b0;
        bus.pc_in = 32'h40;
        resp(32'h10, 32'hB0, 1'b0);
        @(negedge clk);
        check("post_flush_grant", bus.pc_ready, 1);
        tick();
        bus.pc_valid = 1'b0;
        resp(32'h14, 32'hB1, 1'b0);
        @(negedge clk);
        check("flush_drop_valid", bus.inst_valid, 0);
        tick();
        resp(32'h40, 32'hC0, 1'b1);
        @(negedge clk);
        check("flush_new_valid", bus.inst_valid, (LAT == 0) ? 64'd1 : 64'd0);
        tick();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        check("flush_new_valid_late", bus.inst_valid, (LAT == 1) ? 64'd1 : 64'd0);
        tick();
        @(negedge clk);
        check("flush_after_valid", bus.inst_valid, 0);
        tick();

        // Flush coincident with a returning response and a pop
        idle();
        bus.imem_gnt = 1'b1;
        bus.pc_valid = 1'b1;
        bus.pc_in    = 32'h50;
        tick();
        bus.pc_in = 32'h54;
        resp(32'h50, 32'hE0, 1'b1);
        tick();
        bus.pc_valid   = 1'b0;
        bus.flush      = 1'b1;
        bus.inst_ready = 1'b1;
        resp(32'h54, 32'hE1, 1'b0);
        @(negedge clk);
        check("cflush_valid", bus.inst_valid, 1);
        check("cflush_pc", bus.inst_pc, 64'h50);
        check("cflush_req", bus.imem_req, 0);
        tick();
        bus.flush       = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.pc_valid    = 1'b1;
        bus.pc_in       = 32'h60;
        @(negedge clk);
        check("cflush_next_valid", bus.inst_valid, 0);
        check("cflush_regrant", bus.pc_ready, 1);
        tick();
        bus.pc_valid = 1'b0;
        resp(32'h60, 32'hF0, 1'b1);
        tick();
        bus.imem_rvalid = 1'b0;
        tick();
        tick();
        check("sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
